chiptop_jtag_ir_decoder: RTL and testbench
==========================================

# chiptop_jtag_ir_decoder

Parametrised JTAG instruction register and decoder for the CHIPTOP test-access path. It holds the capture/shift/update instruction register and decodes the latched opcode into registered one-hot test-mode selects: the IEEE 1149.1 set, IDCODE, HIGHZ and NUM_USER user channels. It sits between the TAP controller, which supplies the state strobes, and the boundary-scan/TDR muxing. Unknown opcodes fall back to BYPASS.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register width; legal range 2..8.
- EXTEST_CODE, 4'h0, EXTEST opcode.
- SAMPLE_CODE, 4'h1, SAMPLE/PRELOAD opcode (shared).
- IDCODE_CODE, 4'h2, IDCODE opcode.
- CLAMP_CODE, 4'h3, CLAMP opcode.
- HIGHZ_CODE, 4'h4, HIGHZ opcode.
- HAS_IDCODE, 1, 1 = reset instruction is IDCODE; 0 = reset instruction is BYPASS and IDCODE_CODE decodes as BYPASS.
- NUM_USER, 2, number of user instruction channels; legal range 0..8.
- USER_BASE, 4'h8, opcode of USER[0]; USER[k] = USER_BASE+k.

Ports:
- CLK  in  1  TCK-domain clock; all state updates on rising edge.
- RST  in  1  Reset; asynchronous, active-high.
- TLR  in  1  TAP in Test-Logic-Reset; synchronous re-init.
- CAPTURE_IR  in  1  TAP in Capture-IR.
- SHIFT_IR  in  1  TAP in Shift-IR.
- UPDATE_IR  in  1  TAP in Update-IR.
- TDI  in  1  serial data in.
- TDO_IR  out  IR_WIDTH?1:1  serial out, equal to shift_reg[0].
- IR_VALUE  out  IR_WIDTH  latched instruction.
- EXTEST, SAMPLE, PRELOAD, IDCODE, CLAMP, HIGHZ, BYPASS  out  1 each  registered decode.
- USER  out  max(NUM_USER,1)  registered one-hot user selects; tied 0 when NUM_USER=0.
- BSR_SEL  out  1  boundary-scan register is the active TDR.
- BYP_SEL  out  1  bypass register is the active TDR.
- IR_UPDATED  out  1  one-cycle pulse after each instruction latch.

## Operation
- Registers: shift_reg[IR_WIDTH], ir_q[IR_WIDTH], decode flags, IR_UPDATED.
- Reset instruction RST_CODE = IDCODE_CODE if HAS_IDCODE else all-ones.
- Priority per cycle: TLR > UPDATE_IR > CAPTURE_IR > SHIFT_IR. Lower-priority strobes asserted at the same time are ignored.
- TLR: ir_q <= RST_CODE, shift_reg <= RST_CODE, flags re-decoded, IR_UPDATED <= 0.
- CAPTURE_IR: shift_reg <= {zeros, 2'b01}; the two LSBs are fixed per 1149.1.
- SHIFT_IR: shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]}; LSB goes out first.
- UPDATE_IR: ir_q <= shift_reg; all flags <= decode(shift_reg); IR_UPDATED <= 1 for exactly one cycle.
- Decode is one-hot across {EXTEST, SAMPLE, IDCODE, CLAMP, HIGHZ, BYPASS, USER[*]}. PRELOAD is identical to SAMPLE.
- All-ones always decodes as BYPASS.
- Any unassigned opcode decodes as BYPASS.
- Overlap: fixed opcodes take precedence over USER codes. USER codes at or above 2^IR_WIDTH do not exist. Elaboration error if two fixed codes collide.
- BSR_SEL = EXTEST|SAMPLE; registered with the flags.
- BYP_SEL = BYPASS|CLAMP|HIGHZ; registered with the flags.
- Reset values (RST or TLR): IR_VALUE = RST_CODE; IDCODE = HAS_IDCODE; BYPASS = BYP_SEL = !HAS_IDCODE; all other flags, USER, BSR_SEL, IR_UPDATED = 0; TDO_IR = RST_CODE[0].
- The block holds no TAP state. Strobes are assumed mutually exclusive; the priority order above is the required fallback.

## Timing
- Decode latency: flags and IR_VALUE change on the first rising edge on which UPDATE_IR is high, and are valid from that cycle on. There is no combinational path from shift_reg to any flag.
- IR_UPDATED is high in the cycle after the update edge, low otherwise.
- TDO_IR is combinational from shift_reg and changes after each shift edge.
- An IR_WIDTH-bit load needs IR_WIDTH SHIFT_IR cycles.
- Extra shift cycles keep shifting; only the last IR_WIDTH TDI bits survive.
- Async RST mid-shift clears immediately to reset values. After RST deasserts, the first edge obeys normal priority.
- Flags hold their value across capture and shift; they change only on UPDATE_IR, TLR or RST.

## Test plan
- Reset: pulse RST, defaults -> IR_VALUE=4'h2, IDCODE=1, BYPASS=0, TDO_IR=0. Repeat with HAS_IDCODE=0 -> IR_VALUE=4'hF, BYPASS=1, BYP_SEL=1.
- Capture/shift: CAPTURE_IR, then 4 SHIFT_IR cycles with TDI=1,1,0,0 -> TDO_IR sequence 1,0,0,0; shift_reg=4'h3. UPDATE_IR -> CLAMP=1, BYP_SEL=1, IR_UPDATED pulses one cycle.
- Full decode sweep: load each of 0..15 -> 0:EXTEST+BSR_SEL; 1:SAMPLE=PRELOAD=1; 2:IDCODE; 3:CLAMP; 4:HIGHZ; 8:USER=2'b01; 9:USER=2'b10; all others, including F: BYPASS only. Exactly one flag set in every case.
- Simultaneous strobes: UPDATE_IR and SHIFT_IR together -> update wins, shift_reg unchanged. TLR and UPDATE_IR together -> IR_VALUE=RST_CODE, IR_UPDATED=0.
- Mid-operation reset: assert RST after 2 of 4 shift bits -> immediate defaults; a following full load of 4'h4 gives HIGHZ=1.
- Parametric: IR_WIDTH=6, NUM_USER=4, USER_BASE=6'h20 -> shift 6'h23 gives USER=4'b1000; shift 6'h3F gives BYPASS=1; capture value reads out 1,0,0,0,0,0.

Source files
------------

// File: rtl/chiptop_jtag_ir_decoder.sv
// JTAG instruction register with registered one-hot decode of the latched opcode.
// Decode is computed from shift_reg and captured only on UPDATE_IR or TLR.
module chiptop_jtag_ir_decoder #(
    parameter int                  IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0] EXTEST_CODE = 'h0,
    parameter logic [IR_WIDTH-1:0] SAMPLE_CODE = 'h1,
    parameter logic [IR_WIDTH-1:0] IDCODE_CODE = 'h2,
    parameter logic [IR_WIDTH-1:0] CLAMP_CODE  = 'h3,
    parameter logic [IR_WIDTH-1:0] HIGHZ_CODE  = 'h4,
    parameter bit                  HAS_IDCODE  = 1'b1,
    parameter int                  NUM_USER    = 2,
    parameter logic [IR_WIDTH-1:0] USER_BASE   = 'h8
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     TLR,
    input  logic                                     CAPTURE_IR,
    input  logic                                     SHIFT_IR,
    input  logic                                     UPDATE_IR,
    input  logic                                     TDI,
    output logic                                     TDO_IR,
    output logic [IR_WIDTH-1:0]                      IR_VALUE,
    output logic                                     EXTEST,
    output logic                                     SAMPLE,
    output logic                                     PRELOAD,
    output logic                                     IDCODE,
    output logic                                     CLAMP,
    output logic                                     HIGHZ,
    output logic                                     BYPASS,
    output logic [(NUM_USER > 0 ? NUM_USER : 1)-1:0] USER,
    output logic                                     BSR_SEL,
    output logic                                     BYP_SEL,
    output logic                                     IR_UPDATED
);

    localparam int UW = (NUM_USER > 0) ? NUM_USER : 1;
    localparam int FW = 6 + UW;

    // Flag vector layout: 0 extest, 1 sample, 2 idcode, 3 clamp, 4 highz, 5 bypass, 6+ user
    function automatic logic [FW-1:0] decode(input logic [IR_WIDTH-1:0] code);
        logic [FW-1:0] f;
        f = '0;
        if (code == {IR_WIDTH{1'b1}}) begin
            f[5] = 1'b1;
        end else if (code == EXTEST_CODE) begin
            f[0] = 1'b1;
        end else if (code == SAMPLE_CODE) begin
            f[1] = 1'b1;
        end else if (code == IDCODE_CODE) begin
            if (HAS_IDCODE) f[2] = 1'b1;
            else            f[5] = 1'b1;
        end else if (code == CLAMP_CODE) begin
            f[3] = 1'b1;
        end else if (code == HIGHZ_CODE) begin
            f[4] = 1'b1;
        end else begin
            // Codes beyond 2^IR_WIDTH can never match since code is IR_WIDTH bits wide
            for (int k = 0; k < NUM_USER; k++) begin
                if (int'(USER_BASE) + k == int'(code)) f[6+k] = 1'b1;
            end
            if (f[FW-1:6] == '0) f[5] = 1'b1;
        end
        return f;
    endfunction

    localparam logic [IR_WIDTH-1:0] RST_CODE  = HAS_IDCODE ? IDCODE_CODE : {IR_WIDTH{1'b1}};
    localparam logic [FW-1:0]       RST_FLAGS = decode(RST_CODE);
    localparam bit RST_BSR = RST_FLAGS[0] | RST_FLAGS[1];
    localparam bit RST_BYP = RST_FLAGS[3] | RST_FLAGS[4] | RST_FLAGS[5];

    if (EXTEST_CODE == SAMPLE_CODE || EXTEST_CODE == IDCODE_CODE || EXTEST_CODE == CLAMP_CODE ||
        EXTEST_CODE == HIGHZ_CODE  || SAMPLE_CODE == IDCODE_CODE || SAMPLE_CODE == CLAMP_CODE ||
        SAMPLE_CODE == HIGHZ_CODE  || IDCODE_CODE == CLAMP_CODE  || IDCODE_CODE == HIGHZ_CODE ||
        CLAMP_CODE == HIGHZ_CODE) begin : g_code_collision
        $error("chiptop_jtag_ir_decoder: fixed instruction opcodes collide");
    end

    logic [IR_WIDTH-1:0] shift_reg;
    logic [IR_WIDTH-1:0] ir_q;
    logic [FW-1:0]       flags;
    logic [FW-1:0]       next_flags;
    logic                bsr_sel;
    logic                byp_sel;
    logic                updated;

    always_comb begin
        next_flags = decode(shift_reg);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg <= RST_CODE;
            ir_q      <= RST_CODE;
            flags     <= RST_FLAGS;
            bsr_sel   <= RST_BSR;
            byp_sel   <= RST_BYP;
            updated   <= 1'b0;
        end else if (TLR) begin
            shift_reg <= RST_CODE;
            ir_q      <= RST_CODE;
            flags     <= RST_FLAGS;
            bsr_sel   <= RST_BSR;
            byp_sel   <= RST_BYP;
            updated   <= 1'b0;
        end else begin
            updated <= 1'b0;
            if (UPDATE_IR) begin
                ir_q    <= shift_reg;
                flags   <= next_flags;
                bsr_sel <= next_flags[0] | next_flags[1];
                byp_sel <= next_flags[3] | next_flags[4] | next_flags[5];
                updated <= 1'b1;
            end else if (CAPTURE_IR) begin
                shift_reg <= IR_WIDTH'(2'b01);
            end else if (SHIFT_IR) begin
                shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]};
            end
        end
    end

    assign TDO_IR     = shift_reg[0];
    assign IR_VALUE   = ir_q;
    assign EXTEST     = flags[0];
    assign SAMPLE     = flags[1];
    assign PRELOAD    = flags[1];
    assign IDCODE     = flags[2];
    assign CLAMP      = flags[3];
    assign HIGHZ      = flags[4];
    assign BYPASS     = flags[5];
    assign USER       = flags[FW-1:6];
    assign BSR_SEL    = bsr_sel;
    assign BYP_SEL    = byp_sel;
    assign IR_UPDATED = updated;

endmodule

// File: tb/tb_chiptop_jtag_ir_decoder.sv
// Bench for chiptop_jtag_ir_decoder: three configurations driven in lockstep and
// compared every cycle against an integer-level model of the instruction register.
module tb_chiptop_jtag_ir_decoder;

    localparam int PW[3] = '{4, 4, 6};
    localparam int PH[3] = '{1, 0, 1};
    localparam int PN[3] = '{2, 2, 4};
    localparam int PB[3] = '{8, 8, 32};

    logic clk = 1'b0;
    logic rst, tlr, cap, sh, upd, tdi;

    logic       tdo[3], ex[3], sa[3], pre[3], id[3], cl[3], hz[3], byp[3];
    logic       bsrs[3], byps[3], iru[3];
    logic [3:0] ir0, ir1;
    logic [5:0] ir2;
    logic [1:0] u0, u1;
    logic [3:0] u2;
    logic [31:0] irv[3];
    logic [15:0] obs[3];

    int m_sr[3], m_ir[3], m_up[3];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chiptop_jtag_ir_decoder u_dut0 (
        .CLK(clk), .RST(rst), .TLR(tlr), .CAPTURE_IR(cap), .SHIFT_IR(sh), .UPDATE_IR(upd),
        .TDI(tdi), .TDO_IR(tdo[0]), .IR_VALUE(ir0), .EXTEST(ex[0]), .SAMPLE(sa[0]),
        .PRELOAD(pre[0]), .IDCODE(id[0]), .CLAMP(cl[0]), .HIGHZ(hz[0]), .BYPASS(byp[0]),
        .USER(u0), .BSR_SEL(bsrs[0]), .BYP_SEL(byps[0]), .IR_UPDATED(iru[0])
    );

    chiptop_jtag_ir_decoder #(.HAS_IDCODE(1'b0)) u_dut1 (
        .CLK(clk), .RST(rst), .TLR(tlr), .CAPTURE_IR(cap), .SHIFT_IR(sh), .UPDATE_IR(upd),
        .TDI(tdi), .TDO_IR(tdo[1]), .IR_VALUE(ir1), .EXTEST(ex[1]), .SAMPLE(sa[1]),
        .PRELOAD(pre[1]), .IDCODE(id[1]), .CLAMP(cl[1]), .HIGHZ(hz[1]), .BYPASS(byp[1]),
        .USER(u1), .BSR_SEL(bsrs[1]), .BYP_SEL(byps[1]), .IR_UPDATED(iru[1])
    );

    chiptop_jtag_ir_decoder #(.IR_WIDTH(6), .NUM_USER(4), .USER_BASE(6'h20)) u_dut2 (
        .CLK(clk), .RST(rst), .TLR(tlr), .CAPTURE_IR(cap), .SHIFT_IR(sh), .UPDATE_IR(upd),
        .TDI(tdi), .TDO_IR(tdo[2]), .IR_VALUE(ir2), .EXTEST(ex[2]), .SAMPLE(sa[2]),
        .PRELOAD(pre[2]), .IDCODE(id[2]), .CLAMP(cl[2]), .HIGHZ(hz[2]), .BYPASS(byp[2]),
        .USER(u2), .BSR_SEL(bsrs[2]), .BYP_SEL(byps[2]), .IR_UPDATED(iru[2])
    );

    assign irv[0] = {28'd0, ir0};
    assign irv[1] = {28'd0, ir1};
    assign irv[2] = {26'd0, ir2};
    assign obs[0] = {5'd0, u0, byps[0], bsrs[0], pre[0], byp[0], hz[0], cl[0], id[0], sa[0], ex[0]};
    assign obs[1] = {5'd0, u1, byps[1], bsrs[1], pre[1], byp[1], hz[1], cl[1], id[1], sa[1], ex[1]};
    assign obs[2] = {3'd0, u2, byps[2], bsrs[2], pre[2], byp[2], hz[2], cl[2], id[2], sa[2], ex[2]};

    function automatic int rst_code(int d);
        return PH[d] != 0 ? 2 : (1 << PW[d]) - 1;
    endfunction

    // Expected outputs for an opcode: bits 0..5 flags, 6 preload, 7 bsr_sel, 8 byp_sel, 9+ user
    function automatic int ref_obs(int d, int code);
        int sel;
        int o;
        if (code == (1 << PW[d]) - 1)                   sel = 5;
        else if (code == 0)                             sel = 0;
        else if (code == 1)                             sel = 1;
        else if (code == 2)                             sel = (PH[d] != 0) ? 2 : 5;
        else if (code == 3)                             sel = 3;
        else if (code == 4)                             sel = 4;
        else if (code >= PB[d] && code < PB[d] + PN[d]) sel = 6 + code - PB[d];
        else                                            sel = 5;
        o = (sel < 6) ? (1 << sel) : (1 << (9 + sel - 6));
        if (sel == 1) o = o | (1 << 6);
        if (sel <= 1) o = o | (1 << 7);
        if (sel >= 3 && sel <= 5) o = o | (1 << 8);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_sr[d] = rst_code(d);
            m_ir[d] = rst_code(d);
            m_up[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            if (tlr) begin
                m_sr[d] = rst_code(d);
                m_ir[d] = rst_code(d);
                m_up[d] = 0;
            end else begin
                m_up[d] = 0;
                if (upd) begin
                    m_ir[d] = m_sr[d];
                    m_up[d] = 1;
                end else if (cap) begin
                    m_sr[d] = 1;
                end else if (sh) begin
                    m_sr[d] = (m_sr[d] >> 1) | (int'(tdi) << (PW[d] - 1));
                end
            end
        end
    endtask

    task automatic check_models();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d ir_value", d), irv[d], m_ir[d]);
            chk($sformatf("dut%0d flags(ir=0x%0h)", d, m_ir[d]), {16'd0, obs[d]},
                ref_obs(d, m_ir[d]));
            chk($sformatf("dut%0d tdo_ir", d), {31'd0, tdo[d]}, m_sr[d] & 1);
            chk($sformatf("dut%0d ir_updated", d), {31'd0, iru[d]}, m_up[d]);
        end
    endtask

    task automatic cyc(input bit t, input bit c, input bit s, input bit u, input bit d);
        tlr = t; cap = c; sh = s; upd = u; tdi = d;
        @(posedge clk);
        model_edge();
        #1;
        check_models();
    endtask

    task automatic load6(input int code);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 1'((code >> i) & 1));
        cyc(0, 0, 0, 1, 0);
    endtask

    typedef struct {
        bit t, c, s, u, d;
        int ir, tdo, up;
    } vec_t;
    vec_t tbl[9];

    initial begin
        // Reference expectations for the 4-bit IDCODE configuration from reset
        tbl[0] = '{0, 1, 0, 0, 0, 2, 1, 0};  // capture -> 0001
        tbl[1] = '{0, 0, 1, 0, 1, 2, 0, 0};  // 1000
        tbl[2] = '{0, 0, 1, 0, 1, 2, 0, 0};  // 1100
        tbl[3] = '{0, 0, 1, 0, 0, 2, 0, 0};  // 0110
        tbl[4] = '{0, 0, 1, 0, 0, 2, 1, 0};  // 0011
        tbl[5] = '{0, 0, 0, 1, 0, 3, 1, 1};  // update -> CLAMP
        tbl[6] = '{0, 0, 0, 0, 0, 3, 1, 0};
        tbl[7] = '{0, 0, 1, 1, 0, 3, 1, 1};  // update beats shift
        tbl[8] = '{1, 0, 0, 1, 0, 2, 0, 0};  // TLR beats update

        rst = 1'b1; tlr = 0; cap = 0; sh = 0; upd = 0; tdi = 0;
        model_reset();
        #12;
        check_models();
        @(posedge clk);
        #1 rst = 1'b0;

        chk("rst dut0 ir_value", {28'd0, ir0}, 2);
        chk("rst dut0 idcode", {31'd0, id[0]}, 1);
        chk("rst dut0 bypass", {31'd0, byp[0]}, 0);
        chk("rst dut0 tdo_ir", {31'd0, tdo[0]}, 0);
        chk("rst dut1 ir_value", {28'd0, ir1}, 15);
        chk("rst dut1 bypass", {31'd0, byp[1]}, 1);
        chk("rst dut1 byp_sel", {31'd0, byps[1]}, 1);

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].t, tbl[i].c, tbl[i].s, tbl[i].u, tbl[i].d);
            chk($sformatf("tbl[%0d] ir_value", i), {28'd0, ir0}, tbl[i].ir);
            chk($sformatf("tbl[%0d] tdo_ir", i), {31'd0, tdo[0]}, tbl[i].tdo);
            chk($sformatf("tbl[%0d] ir_updated", i), {31'd0, iru[0]}, tbl[i].up);
            if (i == 5) begin
                chk("clamp after 0x3", {31'd0, cl[0]}, 1);
                chk("byp_sel after 0x3", {31'd0, byps[0]}, 1);
            end
        end

        // Async reset in the middle of a shift
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_models();
        chk("mid-shift rst dut0 ir_value", {28'd0, ir0}, 2);
        #2 rst = 1'b0;
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("highz after 0x4", {31'd0, hz[0]}, 1);

        // 6-bit user channel and all-ones
        load6('h23);
        chk("dut2 user 0x23", {28'd0, u2}, 8);
        load6('h3F);
        chk("dut2 bypass 0x3F", {31'd0, byp[2]}, 1);
        cyc(0, 1, 0, 0, 0);
        chk("dut2 capture bit0", {31'd0, tdo[2]}, 1);
        for (int i = 1; i < 6; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk($sformatf("dut2 capture bit%0d", i), {31'd0, tdo[2]}, 0);
        end

        // Sweep every opcode; the 4-bit configurations see code>>2
        for (int code = 0; code < 64; code++) load6(code);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
